// File: rtl/npu_requant_o.sv
// Multi-lane output requantizer. Each lane scales an accumulator by an
// unsigned multiplier, applies a rounding right shift, adds the output zero
// point, optionally clamps at the zero point (ReLU), and saturates to O_LEN.
// It is a 3-stage pipeline with a global stall, and it counts saturated lane
// results as they are delivered downstream.

module npu_requant_o_lane #(
  parameter int M_LEN = 32,
  parameter int O_LEN = 8,
  parameter int I_LEN = 8,
  parameter int MUL_W = 16,
  parameter int SH_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_adv,
  input  logic [M_LEN-1:0] i_data,
  input  logic [MUL_W-1:0] i_mult,
  input  logic [SH_W-1:0]  i_shift,
  input  logic [I_LEN-1:0] i_zp1,
  input  logic [I_LEN-1:0] i_zp2,
  input  logic             i_relu2,
  output logic [O_LEN-1:0] o_data,
  output logic             o_sat
);
  localparam int P_W = M_LEN + MUL_W + 1;   // signed product
  localparam int R_W = P_W + 1;             // rounding headroom
  localparam int S_W = P_W + 2;             // after zero-point add, never wraps
  localparam logic signed [S_W-1:0] HI    = S_W'((2 ** (O_LEN - 1)) - 1);
  localparam logic signed [S_W-1:0] LO    = ~HI;
  localparam logic signed [R_W-1:0] R_ONE = R_W'(1);

  // S1: signed data times zero-extended multiplier
  logic signed [P_W-1:0] w_p, r_p;
  assign w_p = $signed({{(MUL_W+1){i_data[M_LEN-1]}}, i_data})
             * $signed({{M_LEN{1'b0}}, 1'b0, i_mult});

  // S2: (p + 2^(n-1)) >>> n is computed as ((p >>> (n-1)) + 1) >>> 1 so the
  // rounding constant never has to fit in the datapath, even for n = 63.
  logic signed [P_W-1:0] w_t;
  logic signed [R_W-1:0] w_te, w_r;
  logic signed [S_W-1:0] w_s, r_s;
  assign w_t  = r_p >>> (i_shift - SH_W'(1));
  assign w_te = $signed({w_t[P_W-1], w_t}) + R_ONE;
  assign w_r  = (i_shift == '0) ? $signed({r_p[P_W-1], r_p}) : (w_te >>> 1);
  assign w_s  = $signed({w_r[R_W-1], w_r})
              + $signed({{(S_W-I_LEN){i_zp1[I_LEN-1]}}, i_zp1});

  // S3: clamp; the ReLU floor is not counted as saturation
  logic signed [S_W-1:0] w_zp2, w_lo;
  logic [O_LEN-1:0]      w_o;
  logic                  w_sat;
  assign w_zp2 = $signed({{(S_W-I_LEN){i_zp2[I_LEN-1]}}, i_zp2});
  assign w_lo  = (i_relu2 && (w_zp2 > LO)) ? w_zp2 : LO;
  assign w_o   = (r_s > HI)   ? HI[O_LEN-1:0]   :
                 (r_s < w_lo) ? w_lo[O_LEN-1:0] : r_s[O_LEN-1:0];
  assign w_sat = (r_s > HI) || (r_s < LO);

  // lane stage registers, all held while the pipe is stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_p    <= '0;
      r_s    <= '0;
      o_data <= '0;
      o_sat  <= 1'b0;
    end else if (i_adv) begin
      r_p    <= w_p;
      r_s    <= w_s;
      o_data <= w_o;
      o_sat  <= w_sat;
    end
  end
endmodule

module npu_requant_o #(
  parameter int CH    = 4,
  parameter int M_LEN = 32,
  parameter int O_LEN = 8,
  parameter int I_LEN = 8,
  parameter int MUL_W = 16,
  parameter int SH_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [MUL_W-1:0]      cfg_mult_i,
  input  logic [SH_W-1:0]       cfg_shift_i,
  input  logic [I_LEN-1:0]      cfg_zp_i,
  input  logic                  cfg_relu_i,
  input  logic [CH*M_LEN-1:0]   data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [CH*O_LEN-1:0]   data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  idle_o,
  output logic [CNT_W-1:0]      sat_cnt_o,
  input  logic                  sat_clr_i
);
  localparam int STAGES = 3;
  localparam int PC_W   = $clog2(CH + 1);

  logic                w_adv, w_acc, w_deliver;
  logic [STAGES:1]     r_vld_pipe;
  logic [SH_W-1:0]     r_shift1;
  logic [I_LEN-1:0]    r_zp1, r_zp2;
  logic                r_relu1, r_relu2;
  logic [CH-1:0]       w_sat;
  logic [PC_W-1:0]     w_pop;
  logic [CNT_W:0]      w_cnt_sum;
  logic [CNT_W-1:0]    r_cnt;

  assign w_adv     = ~valid_o | ready_i;
  assign ready_o   = w_adv;
  assign w_acc     = valid_i & w_adv;
  assign valid_o   = r_vld_pipe[STAGES];
  assign idle_o    = ~|r_vld_pipe;
  assign w_deliver = valid_o & ready_i;
  assign sat_cnt_o = r_cnt;

  // valid shift register plus the config that travels with each beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
      r_shift1   <= '0;
      r_zp1      <= '0;
      r_relu1    <= 1'b0;
      r_zp2      <= '0;
      r_relu2    <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
      r_shift1   <= cfg_shift_i;
      r_zp1      <= cfg_zp_i;
      r_relu1    <= cfg_relu_i;
      r_zp2      <= r_zp1;
      r_relu2    <= r_relu1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    npu_requant_o_lane #(
      .M_LEN(M_LEN), .O_LEN(O_LEN), .I_LEN(I_LEN), .MUL_W(MUL_W), .SH_W(SH_W)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_adv   (w_adv),
      .i_data  (data_i[k*M_LEN +: M_LEN]),
      .i_mult  (cfg_mult_i),
      .i_shift (r_shift1),
      .i_zp1   (r_zp1),
      .i_zp2   (r_zp2),
      .i_relu2 (r_relu2),
      .o_data  (data_o[k*O_LEN +: O_LEN]),
      .o_sat   (w_sat[k])
    );
  end

  // popcount of lane saturation flags at the output stage
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < CH; k++) w_pop = w_pop + PC_W'(w_sat[k]);
  end

  assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);

  // saturation counter: clear wins, otherwise sticky at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i || sat_clr_i)  r_cnt <= '0;
    else if (w_deliver)      r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  end
endmodule

// File: tb/tb_npu_requant_o.sv
// Directed bench for npu_requant_o: table vectors, streaming/stall, per-beat
// shift change, mid-stream reset and saturation counter corner cases.

module tb_npu_requant_o;
  localparam int CH = 4, M_LEN = 32, O_LEN = 8, I_LEN = 8, MUL_W = 16, SH_W = 6, CNT_W = 16;

  logic                 clk_i = 0, rst_i = 1;
  logic [MUL_W-1:0]     cfg_mult_i = 1;
  logic [SH_W-1:0]      cfg_shift_i = 0;
  logic [I_LEN-1:0]     cfg_zp_i = 0;
  logic                 cfg_relu_i = 0;
  logic [CH*M_LEN-1:0]  data_i = '0;
  logic                 valid_i = 0, ready_i = 1, sat_clr_i = 0;
  logic                 ready_o, valid_o, idle_o;
  logic [CH*O_LEN-1:0]  data_o;
  logic [CNT_W-1:0]     sat_cnt_o;

  npu_requant_o dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_mult_i(cfg_mult_i), .cfg_shift_i(cfg_shift_i),
    .cfg_zp_i(cfg_zp_i), .cfg_relu_i(cfg_relu_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .idle_o(idle_o), .sat_cnt_o(sat_cnt_o), .sat_clr_i(sat_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0]       mult;
    logic [5:0]        shift;
    logic signed [7:0] zp;
    logic              relu;
    int                lane[4];
    int                exp[4];
    int                nsat;
  } vec_t;

  vec_t tbl[8];
  int   checks = 0, errors = 0;
  int   exp_cnt = 0;

  logic [CH*M_LEN-1:0] s_din[8];
  logic [SH_W-1:0]     s_shift[8];
  logic [CH*O_LEN-1:0] s_exp[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic set_vec(input int i);
    cfg_mult_i = tbl[i].mult; cfg_shift_i = tbl[i].shift;
    cfg_zp_i = tbl[i].zp; cfg_relu_i = tbl[i].relu;
    for (int k = 0; k < CH; k++) data_i[k*M_LEN +: M_LEN] = 32'(tbl[i].lane[k]);
  endtask

  // streams s_din/s_shift (mult=1, zp=0) with ready_i low on cycles st_lo..st_hi
  task automatic run_stream(input string name, input int nb, input int st_lo, input int st_hi);
    int sent = 0, got = 0;
    bit hv = 0, saw_stall = 0;
    logic [CH*O_LEN-1:0] held = '0;
    cfg_mult_i = 1; cfg_zp_i = 0; cfg_relu_i = 0;
    for (int cyc = 0; cyc < 60 && got < nb; cyc++) begin
      ready_i = !(cyc >= st_lo && cyc <= st_hi);
      valid_i = (sent < nb);
      if (sent < nb) begin data_i = s_din[sent]; cfg_shift_i = s_shift[sent]; end
      #1;
      if (valid_o && !ready_i) begin
        saw_stall = 1;
        chk({name, "_ready_low"}, ready_o, 0);
        if (hv) chk({name, "_hold"}, data_o, held);
        held = data_o; hv = 1;
      end else hv = 0;
      if (valid_o && ready_i) begin
        chk({name, "_data"}, data_o, s_exp[got]);
        got++;
      end
      if (valid_i && ready_o) sent++;
      @(posedge clk_i); #1;
    end
    valid_i = 0; ready_i = 1;
    chk({name, "_count"}, got, nb);
    if (st_lo <= st_hi) chk({name, "_stall_seen"}, saw_stall, 1);
    for (int c = 0; c < 4; c++) begin tick(); chk({name, "_no_extra"}, valid_o, 0); end
  endtask

  initial begin
    // {mult, shift, zp, relu, lanes, expected lanes, saturated lanes}
    // -133+5 = -128 fits exactly, so vector 0 has two saturated lanes.
    tbl[0] = '{16'd1,   6'd0,  8'sd5,   1'b0, '{200, -200, 10, -133},   '{127, -128, 15, -128}, 2};
    tbl[1] = '{16'd3,   6'd2,  8'sd0,   1'b0, '{5, -5, 6, -6},          '{4, -4, 5, -4},        0};
    // -50-10 clamps to the ReLU floor (no sat); -138 is below -128 (sat).
    tbl[2] = '{16'd1,   6'd0, -8'sd10,  1'b1, '{-50, -128, 0, 200},     '{-10, -10, -10, 127},  2};
    tbl[3] = '{16'd1,   6'd0,  8'sd0,   1'b0, '{127, -128, 100, -1},    '{127, -128, 100, -1},  0};
    tbl[4] = '{16'd300, 6'd12, 8'sd3,   1'b0,
               '{1000, -1000, 32'h7fff_ffff, int'(32'h8000_0000)},      '{76, -70, 127, -128},  2};
    tbl[5] = '{16'hffff, 6'd63, 8'sd3,  1'b0,
               '{32'h7fff_ffff, int'(32'h8000_0000), -1, 5},           '{3, 3, 3, 3},          0};
    tbl[6] = '{16'd1,   6'd0,  8'sd100, 1'b1, '{0, 27, 28, -500},       '{100, 127, 127, 100},  2};
    tbl[7] = '{16'd1,   6'd0,  8'sd0,   1'b0, '{127, -128, 128, -129},  '{127, -128, 127, -128}, 2};

    // reset state
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_sat_cnt", sat_cnt_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_ready_o", ready_o, 1);

    // table: one beat at a time, config scrambled while in flight
    for (int i = 0; i < 8; i++) begin
      set_vec(i); valid_i = 1; ready_i = 1;
      #1 chk("tbl_ready_o", ready_o, 1);
      tick();
      valid_i = 0;
      cfg_mult_i = 16'hffff; cfg_shift_i = 6'd5; cfg_zp_i = 8'd77; cfg_relu_i = 1;
      data_i = {CH{32'h1234_5678}};
      tick();
      chk("tbl_early_valid", valid_o, 0);
      chk("tbl_busy", idle_o, 0);
      tick();
      chk("tbl_valid", valid_o, 1);
      for (int k = 0; k < CH; k++)
        chk($sformatf("tbl%0d_lane%0d", i, k), int'($signed(data_o[k*O_LEN +: O_LEN])), tbl[i].exp[k]);
      tick();
      exp_cnt += tbl[i].nsat;
      chk($sformatf("tbl%0d_sat_cnt", i), sat_cnt_o, exp_cnt);
      chk("tbl_drained", valid_o, 0);
    end

    // reset with two beats in flight
    set_vec(0); valid_i = 1; tick(); tick(); valid_i = 0;
    rst_i = 1; tick(); rst_i = 0;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_idle", idle_o, 1);
    chk("mid_rst_sat_cnt", sat_cnt_o, 0);
    for (int c = 0; c < 5; c++) begin tick(); chk("mid_rst_no_stale", valid_o, 0); end
    exp_cnt = 0;

    // 8 distinct beats, downstream stalled on cycles 2..7
    for (int b = 0; b < 8; b++) begin
      s_shift[b] = 0;
      for (int k = 0; k < CH; k++) begin
        s_din[b][k*M_LEN +: M_LEN] = 32'(b*16 + k + 1);
        s_exp[b][k*O_LEN +: O_LEN] = 8'(b*16 + k + 1);
      end
    end
    run_stream("stall", 8, 2, 7);

    // shift changes every beat: lanes {7,-7,0,1} with shifts 0..3
    begin
      int sh_exp[4][4];
      sh_exp[0] = '{7, -7, 0, 1};
      sh_exp[1] = '{4, -3, 0, 1};
      sh_exp[2] = '{2, -2, 0, 0};
      sh_exp[3] = '{1, -1, 0, 0};
      for (int b = 0; b < 4; b++) begin
        s_shift[b] = SH_W'(b);
        s_din[b] = {32'd1, 32'd0, -32'sd7, 32'd7};
        for (int k = 0; k < CH; k++) s_exp[b][k*O_LEN +: O_LEN] = 8'(sh_exp[b][k]);
      end
    end
    run_stream("shift", 4, 1, 0);
    chk("stream_sat_cnt", sat_cnt_o, exp_cnt);

    // sticky counter: 16400 beats of 4 saturated lanes overflows 2^16-1
    cfg_mult_i = 1; cfg_shift_i = 0; cfg_zp_i = 0; cfg_relu_i = 0;
    data_i = {CH{32'd1000}}; valid_i = 1; ready_i = 1;
    repeat (16400) tick();
    valid_i = 0;
    repeat (5) tick();
    chk("sat_cnt_sticky", sat_cnt_o, 65535);

    // clear in the same cycle as a saturating delivery
    set_vec(0); valid_i = 1; tick(); valid_i = 0;
    for (int w = 0; w < 10 && !valid_o; w++) tick();
    chk("clr_wait_valid", valid_o, 1);
    sat_clr_i = 1; tick(); sat_clr_i = 0;
    chk("clr_sat_cnt", sat_cnt_o, 0);

    // counting resumes after the clear
    set_vec(4); valid_i = 1; tick(); valid_i = 0;
    repeat (4) tick();
    chk("post_clr_sat_cnt", sat_cnt_o, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
